// File: rtl/status_alarm_bank_pkg.sv
// Shared monitor definitions for the sticky-alarm status bank: register offsets
// within the 32-word block and the layout of the FIRST register.
package status_alarm_bank_pkg;

   localparam logic [4:0] OFF_ALARMS     = 5'd0;
   localparam logic [4:0] OFF_LIVE       = 5'd1;
   localparam logic [4:0] OFF_MASK       = 5'd2;
   localparam logic [4:0] OFF_FIRST      = 5'd3;
   localparam logic [4:0] OFF_COUNT_BASE = 5'd16;

   localparam int FIRST_VALID_BIT = 15;
   localparam int FIRST_IDX_W     = 5;

   // Packs the FIRST register read word from its valid flag and channel index.
   function automatic logic [15:0] first_word(input logic valid, input logic [FIRST_IDX_W-1:0] idx);
      logic [15:0] w;
      w = '0;
      w[FIRST_VALID_BIT] = valid;
      w[FIRST_IDX_W-1:0] = idx;
      return w;
   endfunction

endpackage

// File: rtl/status_alarm_bank_alarm_channel.sv
// One alarm channel: synchroniser, glitch filter, rising-edge detector and a
// saturating occurrence counter.
module alarm_channel #(
   parameter int FILTER_LEN = 1,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alarm_n,
   input  logic             clr_cnt,
   output logic             qual,
   output logic             rise,
   output logic [CNT_W-1:0] count
);

   localparam int               FW       = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0]    FILT_MAX = FW'(FILTER_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [1:0]       sync_reg;
   logic [FW-1:0]    filt_reg;
   logic             qual_prev_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   assign qual  = (filt_reg == FILT_MAX);
   assign rise  = qual & ~qual_prev_reg;
   assign count = count_reg;

   // A clear that coincides with a new occurrence leaves exactly that occurrence counted.
   always_comb begin
      count_next = count_reg;
      if (clr_cnt) begin
         count_next = rise ? CNT_W'(1) : '0;
      end else if (rise && (count_reg != CNT_MAX)) begin
         count_next = count_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg      <= '0;
         filt_reg      <= '0;
         qual_prev_reg <= 1'b0;
         count_reg     <= '0;
      end else begin
         sync_reg      <= {sync_reg[0], ~alarm_n};
         if (!sync_reg[1]) begin
            filt_reg <= '0;
         end else if (filt_reg != FILT_MAX) begin
            filt_reg <= filt_reg + FW'(1);
         end
         qual_prev_reg <= qual;
         count_reg     <= count_next;
      end
   end

endmodule

// File: rtl/status_alarm_bank.sv
// Sticky alarm / status register bank: per-channel qualification, ALARMS, MASK,
// FIRST and COUNT registers on the monitor bus, and a maskable interrupt.
module status_alarm_bank
   import status_alarm_bank_pkg::*;
#(
   parameter int          N_ALARMS   = 12,
   parameter int          FILTER_LEN = 1,
   parameter int          CNT_W      = 8,
   parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                read_en,
   input  logic                write_en,
   input  logic [15:0]         addr,
   input  logic [15:0]         data_in,
   output logic [15:0]         data_out,
   input  logic [N_ALARMS-1:0] alarm_n,
   output logic                irq
);

   logic [N_ALARMS-1:0]            qual_vec;
   logic [N_ALARMS-1:0]            rise_vec;
   logic [N_ALARMS-1:0]            clr_cnt_vec;
   logic [N_ALARMS-1:0][CNT_W-1:0] count_vec;

   logic [N_ALARMS-1:0]    alarms_reg;
   logic [N_ALARMS-1:0]    alarms_next;
   logic [N_ALARMS-1:0]    mask_reg;
   logic                   first_valid_reg;
   logic [FIRST_IDX_W-1:0] first_idx_reg;
   logic [FIRST_IDX_W-1:0] first_sel;
   logic                   first_hold;
   logic [15:0]            data_out_reg;
   logic [15:0]            rd_mux;
   logic                   irq_reg;

   logic       hit;
   logic [4:0] off;
   logic       wr_alarms;
   logic       wr_mask;
   logic       wr_first;

   assign hit       = (addr[15:5] == BASE_ADDR[15:5]);
   assign off       = addr[4:0];
   assign wr_alarms = write_en & hit & (off == OFF_ALARMS);
   assign wr_mask   = write_en & hit & (off == OFF_MASK);
   assign wr_first  = write_en & hit & (off == OFF_FIRST);

   generate
      for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_chan
         assign clr_cnt_vec[gi] = write_en & hit & (off == (OFF_COUNT_BASE + 5'(gi)));

         alarm_channel #(
            .FILTER_LEN (FILTER_LEN),
            .CNT_W      (CNT_W)
         ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .alarm_n (alarm_n[gi]),
            .clr_cnt (clr_cnt_vec[gi]),
            .qual    (qual_vec[gi]),
            .rise    (rise_vec[gi]),
            .count   (count_vec[gi])
         );
      end
   endgenerate

   // New edges are OR-ed in after the clear so a same-cycle set survives the write.
   assign alarms_next = (alarms_reg & ~(wr_alarms ? data_in[N_ALARMS-1:0] : '0)) | rise_vec;

   // Descending scan so the lowest qualifying channel is the one left selected.
   always_comb begin
      first_sel = '0;
      for (int i = N_ALARMS - 1; i >= 0; i--) begin
         if (rise_vec[i]) begin
            first_sel = FIRST_IDX_W'(i);
         end
      end
   end

   // A write to FIRST releases the hold, so an edge in that same cycle is captured.
   assign first_hold = first_valid_reg & ~wr_first;

   always_comb begin
      rd_mux = '0;
      if (hit) begin
         case (off)
            OFF_ALARMS: rd_mux[N_ALARMS-1:0] = alarms_reg;
            OFF_LIVE:   rd_mux[N_ALARMS-1:0] = qual_vec;
            OFF_MASK:   rd_mux[N_ALARMS-1:0] = mask_reg;
            OFF_FIRST:  rd_mux = first_word(first_valid_reg, first_idx_reg);
            default: begin
               for (int i = 0; i < N_ALARMS; i++) begin
                  if (off == (OFF_COUNT_BASE + 5'(i))) begin
                     rd_mux[CNT_W-1:0] = count_vec[i];
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alarms_reg      <= '0;
         mask_reg        <= '1;
         first_valid_reg <= 1'b0;
         first_idx_reg   <= '0;
         data_out_reg    <= '0;
         irq_reg         <= 1'b0;
      end else begin
         alarms_reg <= alarms_next;
         if (wr_mask) begin
            mask_reg <= data_in[N_ALARMS-1:0];
         end
         if (!first_hold && (|rise_vec)) begin
            first_valid_reg <= 1'b1;
            first_idx_reg   <= first_sel;
         end else if (wr_first) begin
            first_valid_reg <= 1'b0;
            first_idx_reg   <= '0;
         end
         data_out_reg <= read_en ? rd_mux : '0;
         irq_reg      <= |(alarms_reg & mask_reg);
      end
   end

   assign data_out = data_out_reg;
   assign irq      = irq_reg;

endmodule

// File: doc/status_alarm_bank.md
# status_alarm_bank

Parametrised sticky-alarm and status register bank for the monitor. It latches active-low AGC alarm inputs through a synchroniser and a per-channel glitch filter, and counts alarm occurrences per channel. It also records which alarm fired first and raises a maskable interrupt. It sits on the monitor register bus alongside the other status sources. Its `data_out` is OR-combined with theirs, so it drives zero whenever it is not returning read data.

## Interface
- `N_ALARMS`, 12: number of alarm channels, 1..16.
- `FILTER_LEN`, 1: consecutive synchronised-low cycles required to qualify an alarm, 1..255.
- `CNT_W`, 8: width of each saturating occurrence counter, 1..16.
- `BASE_ADDR`, 16'h0000: register block base address; aligned to 32 words.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `read_en` in 1: one-cycle read strobe.
- `write_en` in 1: one-cycle write strobe.
- `addr` in 16: register address.
- `data_in` in 16: write data.
- `data_out` out 16: read data; zero except in the cycle after a decoded read.
- `alarm_n` in N_ALARMS: raw active-low alarm inputs, asynchronous to `clk`.
- `irq` out 1: registered level, high while any unmasked sticky alarm is set.

## Operation
- Offsets from BASE_ADDR:
  - 0 ALARMS: sticky alarm bits; write-1-to-clear.
  - 1 LIVE: qualified alarm state; read-only.
  - 2 MASK: interrupt enable mask; R/W; reset value all-ones.
  - 3 FIRST: bit 15 = valid, bits 4:0 = channel index; any write clears it.
  - 16+i COUNT[i]: occurrence count for channel i, zero-extended; any write clears it.
- Register widths: ALARMS, LIVE and MASK use bits N_ALARMS-1:0; upper bits read 0 and ignore writes.
- Undecoded addresses: reads return 0 but still produce the one-cycle response slot; writes have no effect.
- Input path, per channel:
  - 2-flop synchroniser on `~alarm_n[i]`.
  - Filter counter: increments while the synchronised level is high, saturating at FILTER_LEN; resets to 0 whenever the synchronised level is low.
  - `qual[i]` = (filter counter == FILTER_LEN). LIVE reflects `qual`.
- Rising edge of `qual[i]` (registered previous value):
  - sets ALARMS[i];
  - increments COUNT[i], saturating at 2^CNT_W-1;
  - qualifies channel i for FIRST capture.
- FIRST capture: FIRST is loaded with the qualifying channel index and valid=1 on a cycle when valid is 0 and at least one rising edge qualifies. If several edges qualify in the same cycle, the lowest index wins. While valid is 1, FIRST holds.
- Simultaneous clear and set on one channel in one cycle: set wins. This differs from the old block, where writes blocked sets.
- COUNT[i] clear coinciding with an increment: the result is 1.
- Channel held asserted: latches once and counts once. It re-arms only after the synchronised input deasserts.
- `irq` = |(ALARMS & MASK), registered.

## Timing
- Reset: every state returns to its reset value on the first `clk` edge with `rst` high.
  - `data_out` = 0, `irq` = 0.
  - ALARMS, COUNT, FIRST, synchronisers and filters = 0; MASK = all-ones.
- Reset mid-operation: any in-flight read response is dropped.
- Alarm latency: `alarm_n` low and stable before edge E.
  - `qual` high after edge E+1+FILTER_LEN.
  - ALARMS bit and COUNT update after edge E+2+FILTER_LEN.
  - `irq` high after edge E+3+FILTER_LEN.
- Read handshake:
  - `read_en` sampled at edge R; `data_out` is valid during the cycle after R only, then returns to 0.
  - Back-to-back reads on consecutive cycles give back-to-back responses.
  - Read data is the register value sampled at edge R, before that edge's updates.
- Writes take effect at the sampling edge.
- `read_en` and `write_en` together: the write is performed, and the read returns the pre-write value.
- Pulses shorter than FILTER_LEN synchronised cycles never latch.

## Structure
- Shared package/header (existing monitor defs file):
  - offset constants: ALARMS, LIVE, MASK, FIRST, COUNT_BASE;
  - FIRST valid-bit position.
- One sub-module `alarm_channel`, instantiated N_ALARMS times via generate:
  - contains synchroniser, filter counter, edge detector and saturating counter;
  - inputs: `clr_cnt`; outputs: `qual`, `rise`, `count`.
- Top level holds ALARMS, MASK, FIRST, the address decode and the read pipeline.

## Test plan
- Reset, then read each of offsets 0-3 and 16 → 0, 0, 16'h0FFF (N_ALARMS=12), 0, 0; `irq`=0.
- FILTER_LEN=3:
  - 2-cycle low pulse on ch 5 → ALARMS=0, COUNT[5]=0.
  - 4-cycle low pulse on ch 5 → ALARMS=16'h0020, COUNT[5]=1, FIRST=16'h8005, `irq`=1 exactly FILTER_LEN+3 edges after the input drops.
- Ch 2 and ch 7 qualify on the same cycle → FIRST=16'h8002. A later ch 0 event leaves FIRST unchanged; after a write to FIRST, the next ch 0 event gives FIRST=16'h8000.
- Write ALARMS=16'h0004 on the same cycle ch 2 rises → bit 2 stays 1. A write with no concurrent event clears it, and `irq` falls one cycle later.
- MASK=0 with alarms pending → `irq`=0. Then MASK=16'h0001 with ch 0 set → `irq`=1.
- CNT_W=2, pulse ch 1 five times → COUNT[1]=3 (saturated). Write COUNT[1] → reads 0.
